// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter sharing one MemoryController between the
//                instruction fetch path and the load/store path. Holds one
//                owner at a time, drives the controller from that owner's
//                held request, and routes ready/result back. A fetch flushed
//                while in flight is drained without aborting the controller.
//  Options     : MEM_ARB_ROUND_ROBIN_EN - round-robin tie break between
//                fetch and data (default: data always wins ties).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    // instruction fetch port
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_ready,
    output logic [31:0] i_data,
    // load/store port
    input  logic        d_valid,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_len,
    input  logic [31:0] d_data,
    output logic        d_ready,
    output logic [31:0] d_res,
    // memory controller port
    output logic        mem_valid,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_res
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [2:0] c_LEN_WORD = 3'b010;

    state_t      r_state;
    logic [31:0] r_drain_addr;
    logic        w_i_req;
    logic        w_pick_d;

    // A fetch flushed in the same cycle is never a candidate for grant
    assign w_i_req = i_valid & ~i_flush;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // On a tie the side that did not win last time takes the controller
    assign w_pick_d = d_valid & (~w_i_req | ~r_last_d);
`else
    // Fixed priority: data always wins a tie
    assign w_pick_d = d_valid;
`endif

    // Ownership state machine; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_drain_addr <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d     <= 1'b0;
`endif
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_d) begin
                        r_state <= ST_SERVE_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d <= 1'b1;
`endif
                    end else if (w_i_req) begin
                        r_state <= ST_SERVE_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d <= 1'b0;
`endif
                    end
                end
                ST_SERVE_I: begin
                    // A flushed fetch keeps the controller busy until it
                    // finishes; the address is latched because the fetch
                    // side is free to move on immediately.
                    if (mem_ready) begin
                        r_state <= ST_IDLE;
                    end else if (i_flush) begin
                        r_state      <= ST_DRAIN;
                        r_drain_addr <= i_addr;
                    end
                end
                ST_SERVE_D: begin
                    if (mem_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Controller request and completion routing for the current owner
    always_comb begin
        mem_valid = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_len   = 3'b000;
        mem_data  = 32'h0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (r_state)
            ST_SERVE_I: begin
                mem_valid = 1'b1;
                mem_addr  = i_addr;
                mem_len   = c_LEN_WORD;
                i_ready   = mem_ready & ~i_flush & rdy_in;
            end
            ST_SERVE_D: begin
                mem_valid = 1'b1;
                mem_wr    = d_wr;
                mem_addr  = d_addr;
                mem_len   = d_len;
                mem_data  = d_data;
                d_ready   = mem_ready & rdy_in;
            end
            ST_DRAIN: begin
                mem_valid = 1'b1;
                mem_addr  = r_drain_addr;
                mem_len   = c_LEN_WORD;
            end
            default: begin
                mem_valid = 1'b0;
            end
        endcase
    end

    // Results are qualified by the ready pulses, so no masking is needed
    assign i_data = mem_res;
    assign d_res  = mem_res;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: table of single
//                transactions, hand sequences for tie-break, flush/drain,
//                rdy_in stall and async reset, then randomized traffic
//                against a transaction-level reference model.
//  Options     : MEM_ARB_ROUND_ROBIN_EN - selects expected tie-break order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] i_data;
    logic        d_valid;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [2:0]  d_len;
    logic [31:0] d_data;
    logic        d_ready;
    logic [31:0] d_res;
    logic        mem_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] mem_res;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter u_dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .i_valid  (i_valid),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .d_valid  (d_valid),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_len    (d_len),
        .d_data   (d_data),
        .d_ready  (d_ready),
        .d_res    (d_res),
        .mem_valid(mem_valid),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_len  (mem_len),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .mem_res  (mem_res)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] res;
        int          delay;
        logic        exp_wr;
        logic [2:0]  exp_len;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        rdy_in    = 1'b1;
        i_valid   = 1'b0;
        i_addr    = 32'h0;
        i_flush   = 1'b0;
        d_valid   = 1'b0;
        d_wr      = 1'b0;
        d_addr    = 32'h0;
        d_len     = 3'b000;
        d_data    = 32'h0;
        mem_ready = 1'b0;
        mem_res   = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    // One isolated transaction from the table, starting in IDLE
    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            d_valid = 1'b1; d_wr = v.wr; d_addr = v.addr; d_len = v.len; d_data = v.wdata;
        end else begin
            i_valid = 1'b1; i_addr = v.addr;
        end
        mem_ready = 1'b0;
        #1 chk("vec_idle_no_req", {31'h0, mem_valid}, 32'h0);
        tick();
        for (int k = 0; k <= v.delay; k++) begin
            mem_ready = (k == v.delay);
            mem_res   = (k == v.delay) ? v.res : 32'h5A5A_5A5A;
            #1;
            chk("vec_bus", {27'h0, mem_valid, mem_wr, mem_len}, {27'h0, 1'b1, v.exp_wr, v.exp_len});
            chk("vec_addr", mem_addr, v.addr);
            chk("vec_mdata", mem_data, v.exp_mdata);
            chk("vec_ready", {30'h0, i_ready, d_ready},
                (k == v.delay) ? (v.is_d ? 32'h1 : 32'h2) : 32'h0);
            if (k == v.delay)
                chk("vec_result", v.is_d ? d_res : i_data, v.res);
            tick();
        end
        i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
        #1 chk("vec_back_idle", {31'h0, mem_valid}, 32'h0);
    endtask

    // reference model state (transaction level)
    int          m_owner;   // 0 none, 1 fetch, 2 data
    bit          m_cancel;  // owned fetch was flushed
    logic        t_wr;
    logic [31:0] t_addr;
    logic [2:0]  t_len;
    logic [31:0] t_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit          m_last_d;
`endif

    initial begin
        logic        got[4];
        logic        exp_ord[4];
        int          n, fi, di;
        bit          f_pend, d_pend, fl, pi, pd, give_d, e_i, e_d;
        logic [31:0] f_addr;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 3'b000, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 3'b010, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_2001, 3'b100, 32'h0000_AAAA, 32'hFFFF_FF80, 1, 1'b0, 3'b100, 32'h0000_AAAA};
        tbl[2] = '{1'b1, 1'b1, 32'h0003_0000, 3'b010, 32'h1234_5678, 32'h0,         4, 1'b1, 3'b010, 32'h1234_5678};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_1002, 3'b001, 32'h0,         32'h0000_BEEF, 2, 1'b0, 3'b001, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_2000, 3'b000, 32'h0,         32'h1357_9BDF, 3, 1'b0, 3'b010, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0043, 3'b000, 32'h0000_00C3, 32'h0,         0, 1'b1, 3'b000, 32'h0000_00C3};

        // ---------------- reset state ----------------
        clear_inputs();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        #1;
        chk("rst_ctrl", {25'h0, mem_valid, mem_wr, mem_len, i_ready, d_ready}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_mdata", mem_data, 32'h0);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // ---------------- tie-break order ----------------
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_ord[0] = 1'b1; exp_ord[1] = 1'b0; exp_ord[2] = 1'b1; exp_ord[3] = 1'b0;
`else
        exp_ord[0] = 1'b1; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0; exp_ord[3] = 1'b0;
`endif
        for (int i = 0; i < 4; i++) got[i] = 1'bx;
        n = 0; fi = 2; di = 2;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            i_valid = (fi > 0); i_addr = 32'h700 + fi;
            d_valid = (di > 0); d_wr = 1'b0; d_addr = 32'h800 + di; d_len = 3'b010;
            #1 mem_ready = mem_valid;
            #1;
            if (d_ready) begin got[n] = 1'b1; n++; di--; end
            else if (i_ready) begin got[n] = 1'b0; n++; fi--; end
            tick();
        end
        clear_inputs();
        chk("tie_count", n, 4);
        for (int i = 0; i < 4; i++) chk("tie_order", {31'h0, got[i]}, {31'h0, exp_ord[i]});

        // ---------------- flush while fetch in flight ----------------
        do_reset();
        i_valid = 1'b1; i_addr = 32'h400;
        tick();                                   // SERVE_I entered
        #1 chk("fl_serve_addr", mem_addr, 32'h400);
        tick();
        i_flush = 1'b1;                           // one cycle after entry
        #1 chk("fl_no_iready", {31'h0, i_ready}, 32'h0);
        tick();                                   // DRAIN
        i_flush = 1'b0; i_valid = 1'b0; i_addr = 32'h999;
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h500; d_len = 3'b010;
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            #1;
            chk("fl_drain_bus", {26'h0, mem_valid, mem_wr, mem_len, i_ready, d_ready},
                {26'h0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0});
            chk("fl_drain_addr", mem_addr, 32'h400);
            tick();
        end
        mem_ready = 1'b0;
        #1 chk("fl_idle_after_drain", {31'h0, mem_valid}, 32'h0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("fl_load_addr", mem_addr, 32'h500);
        chk("fl_load_ready", {30'h0, i_ready, d_ready}, 32'h1);
        tick();
        clear_inputs();

        // ---------------- rdy_in stall in SERVE_D ----------------
        d_valid = 1'b1; d_addr = 32'h600; d_len = 3'b110;
        tick();
        tick();                                   // SERVE_D entered
        for (int k = 0; k < 3; k++) begin
            rdy_in = 1'b0; mem_ready = 1'b1; mem_res = 32'hCAFE_F00D;
            #1;
            chk("stall_no_ready", {30'h0, mem_valid, d_ready}, 32'h2);
            chk("stall_addr", mem_addr, 32'h600);
            tick();
        end
        rdy_in = 1'b1;
        #1;
        chk("stall_release", {31'h0, d_ready}, 32'h1);
        chk("stall_res", d_res, 32'hCAFE_F00D);
        tick();
        clear_inputs();
        #1 chk("stall_idle", {31'h0, mem_valid}, 32'h0);

        // ---------------- async reset during SERVE_D ----------------
        d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h3_0000; d_len = 3'b010; d_data = 32'h1234_5678;
        tick();
        tick();                                   // SERVE_D entered
        mem_ready = 1'b1;
        #1 chk("arst_pre_dready", {31'h0, d_ready}, 32'h1);
        #1 rst_in = 1'b1;
        #1;
        chk("arst_ctrl", {25'h0, mem_valid, mem_wr, mem_len, i_ready, d_ready}, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_mdata", mem_data, 32'h0);
        clear_inputs();
        tick();
        rst_in = 1'b0;
        tick();
        #1 chk("arst_idle", {30'h0, mem_valid, mem_wr}, 32'h0);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        m_owner = 0; m_cancel = 1'b0;
        t_wr = 1'b0; t_addr = 32'h0; t_len = 3'b0; t_data = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_last_d = 1'b0;
`endif
        f_pend = 1'b0; d_pend = 1'b0; f_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            fl     = rdy_in && ($urandom_range(0, 15) == 0);
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1'b1;
                f_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_wr   = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_len  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
                d_data = $urandom;
            end
            i_valid   = f_pend;
            i_addr    = f_addr;
            i_flush   = fl;
            d_valid   = d_pend;
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_res   = $urandom;
            #1;
            e_i = (m_owner == 1) && !m_cancel && mem_ready && !i_flush && rdy_in;
            e_d = (m_owner == 2) && mem_ready && rdy_in;
            if (m_owner != 0) begin
                chk("rnd_bus", {25'h0, mem_valid, mem_wr, mem_len, i_ready, d_ready},
                    {25'h0, 1'b1, t_wr, t_len, e_i, e_d});
                chk("rnd_addr", mem_addr, t_addr);
                chk("rnd_mdata", mem_data, t_data);
            end else begin
                chk("rnd_idle", {28'h0, mem_valid, mem_wr, i_ready, d_ready}, 32'h0);
            end
            if (e_i) chk("rnd_idata", i_data, mem_res);
            if (e_d) chk("rnd_dres", d_res, mem_res);

            if (rdy_in) begin
                if (m_owner == 0) begin
                    pi = i_valid && !i_flush;
                    pd = d_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    give_d = (pi && pd) ? !m_last_d : pd;
`else
                    give_d = pd;
`endif
                    if (give_d) begin
                        m_owner = 2;
                        t_wr = d_wr; t_addr = d_addr; t_len = d_len; t_data = d_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        m_last_d = 1'b1;
`endif
                    end else if (pi) begin
                        m_owner = 1; m_cancel = 1'b0;
                        t_wr = 1'b0; t_addr = i_addr; t_len = 3'b010; t_data = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        m_last_d = 1'b0;
`endif
                    end
                end else if (mem_ready) begin
                    m_owner = 0; m_cancel = 1'b0;
                end else if (m_owner == 1 && i_flush) begin
                    m_cancel = 1'b1;
                end
            end
            if (fl || e_i) f_pend = 1'b0;
            if (e_d) d_pend = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
